// File: rtl/vlog_xing_pkg.sv
// Shared encodings for the street and pedestrian crossing controllers.
package vlog_xing_pkg;

    localparam int unsigned TIMER_W = 4;

    typedef enum logic [4:0] {
        StreetReset = 5'h01,
        StreetSr0   = 5'h02,
        StreetSr1   = 5'h04,
        StreetSy    = 5'h08,
        StreetSg    = 5'h10
    } street_state_e;

    typedef enum logic [4:0] {
        PedIdle  = 5'h01,
        PedReq   = 5'h02,
        PedWalk  = 5'h04,
        PedFlash = 5'h08,
        PedClear = 5'h10
    } ped_state_e;

    // Any non-one-hot or non-red street value is treated as unsafe for walking.
    function automatic logic is_red(input logic [4:0] s);
        return (s == StreetSr0) || (s == StreetSr1);
    endfunction

endpackage

// File: rtl/vlog_btn_sync.sv
// Push-button synchronizer with rising-edge detect: one btn_evt pulse per press.
module vlog_btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic btn_evt
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign btn_evt = sync2_q & ~prev_q;

endmodule

// File: rtl/vlog_ped_xing_fsm.sv
// Pedestrian crossing controller driven by the street controller's one-hot state.
// Optional button synchronizer enabled by PED_BTN_SYNC_EN.
module vlog_ped_xing_fsm
    import vlog_xing_pkg::*;
#(
    parameter int unsigned WALK_CYC  = 6,
    parameter int unsigned FLASH_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          street_state,
    input  logic                button,
    output logic                ped_waiting,
    output logic                walk,
    output logic                flash,
    output logic                dont_walk,
    output logic [TIMER_W-1:0]  countdown,
    output logic                conflict,
    output logic [4:0]          state_out
);

    localparam logic [TIMER_W-1:0] WalkLoad  = TIMER_W'(WALK_CYC - 1);
    localparam logic [TIMER_W-1:0] FlashLoad = TIMER_W'(FLASH_CYC - 1);

    ped_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               req_q, req_d;
    logic               conflict_q, conflict_d;
    logic               btn_evt;
    logic               red_ok;

`ifdef PED_BTN_SYNC_EN
    vlog_btn_sync u_btn_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .button  (button),
        .btn_evt (btn_evt)
    );
`else
    assign btn_evt = button;
`endif

    assign red_ok = is_red(street_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PedIdle;
            timer_q    <= '0;
            req_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            req_q      <= req_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        conflict_d = conflict_q;
        req_d      = req_q | btn_evt;
        case (state_q)
            PedIdle: begin
                if (req_q || btn_evt) state_d = PedReq;
            end
            PedReq: begin
                if (red_ok) begin
                    state_d = PedWalk;
                    timer_d = WalkLoad;
                    req_d   = 1'b0;  // a press landing on WALK entry is absorbed
                end
            end
            PedWalk: begin
                if (!red_ok) begin
                    state_d    = PedClear;
                    conflict_d = 1'b1;
                end else if (timer_q == '0) begin
                    state_d = PedFlash;
                    timer_d = FlashLoad;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            PedFlash: begin
                if (!red_ok) begin
                    state_d    = PedClear;
                    conflict_d = 1'b1;
                end else if (timer_q == '0) begin
                    state_d = PedClear;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            PedClear: begin
                // Hold until red ends so one red phase never yields two walks.
                if (!red_ok) state_d = req_q ? PedReq : PedIdle;
            end
            default: state_d = PedIdle;
        endcase
    end

    always_comb begin
        walk      = 1'b0;
        flash     = 1'b0;
        dont_walk = 1'b0;
        countdown = '0;
        case (state_q)
            PedWalk: walk = 1'b1;
            PedFlash: begin
                flash     = 1'b1;
                countdown = timer_q + 1'b1;
            end
            default: dont_walk = 1'b1;
        endcase
    end

    assign ped_waiting = req_q;
    assign conflict    = conflict_q;
    assign state_out   = state_q;

endmodule

// File: doc/vlog_ped_xing_fsm.md
Name: vlog_ped_xing_fsm

Overview:
Pedestrian crossing controller on the far side of the street-light protocol. It consumes the street controller's one-hot state and drives the walk / flashing / don't-walk heads. It latches button presses and presents them as a request (ped_waiting) that feeds the street controller's waiting_cross input. Walk is only granted while the street is red; the block aborts to don't-walk if red ends early.

Parameters:
WALK_CYC, 6, cycles of steady WALK (legal 1..15)
FLASH_CYC, 4, cycles of flashing don't-walk with countdown (legal 1..15)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
street_state  input  5  street controller one-hot state: RESET=5'h01, SR0=5'h02, SR1=5'h04, SY=5'h08, SG=5'h10
button  input  1  pedestrian push button
ped_waiting  output  1  registered request pending, to street waiting_cross
walk  output  1  steady WALK head
flash  output  1  flashing don't-walk phase
dont_walk  output  1  steady don't-walk head
countdown  output  4  remaining FLASH cycles, 0 outside FLASH
conflict  output  1  sticky: walk/flash aborted because street left red
state_out  output  5  one-hot state: IDLE=5'h01, REQ=5'h02, WALK=5'h04, FLASH=5'h08, CLEAR=5'h10

Behaviour:
- Reset (async assert, sync release): state IDLE, req_pend=0, timer=0, conflict=0; outputs dont_walk=1, others 0.
- red_ok = (street_state==SR0)||(street_state==SR1). RESET, SY, SG and any non-one-hot value are not red_ok.
- btn_evt: one cycle per press (see Optional Feature). It sets req_pend. req_pend clears on the cycle WALK is entered; a btn_evt coincident with WALK entry is absorbed. Presses during WALK/FLASH/CLEAR set req_pend for the next cycle. ped_waiting = req_pend.
- IDLE: if req_pend or btn_evt -> REQ.
- REQ: if red_ok -> WALK, timer <= WALK_CYC-1. Else stay.
- WALK: if !red_ok -> CLEAR and conflict<=1 (abort has priority over timer). Elif timer==0 -> FLASH, timer <= FLASH_CYC-1. Else timer--.
- FLASH: if !red_ok -> CLEAR and conflict<=1. Elif timer==0 -> CLEAR. Else timer--.
- CLEAR: wait for !red_ok, so there is never a second walk in the same red phase. Then -> REQ if req_pend, else IDLE.
- Outputs are a Moore decode of the state register, so they change the cycle after a transition edge:
  - IDLE/REQ/CLEAR: dont_walk=1.
  - WALK: walk=1.
  - FLASH: flash=1, countdown=timer+1 (FLASH_CYC..1).
  - walk, flash and dont_walk are exactly one-hot at all times.
- Latency: REQ with red_ok at edge N gives walk=1 after edge N. WALK lasts exactly WALK_CYC cycles and FLASH exactly FLASH_CYC cycles absent abort.
- Timer is 4-bit and never wraps; a decrement only happens when timer!=0.
- conflict clears only on reset.
- Illegal state_out encoding: next state is IDLE with dont_walk=1.

Optional Feature:
PED_BTN_SYNC_EN.
- Defined: button passes through a 2-flop synchronizer plus rising-edge detect. btn_evt pulses once per press and a held button does not re-request. Press-to-ped_waiting latency is 3 cycles.
- Undefined: button is taken as synchronous and btn_evt = button (level). Latency is 1 cycle, and a held button re-sets req_pend every cycle.

Decomposition:
- Package vlog_xing_pkg holds:
  - street state encodings (RESET/SR0/SR1/SY/SG), shared with the street controller;
  - pedestrian state encodings;
  - the timer width constant (4).
- Sub-module vlog_btn_sync (synchronizer + edge detect). It is instantiated only under PED_BTN_SYNC_EN.

Test Plan:
- Reset mid-WALK: assert rst_n=0 while walk=1 -> same cycle dont_walk=1, walk=0, ped_waiting=0, conflict=0, state_out=5'h01.
- Normal crossing (sync undefined): street=SG, 1-cycle button -> ped_waiting=1 next cycle. Street->SR0 -> walk=1 for 6 cycles, then flash=1 with countdown 4,3,2,1, then dont_walk=1 with state CLEAR. Street->SG -> IDLE, ped_waiting=0.
- Early abort: enter WALK, street->SY on the 3rd WALK cycle -> next cycle dont_walk=1, conflict=1, state CLEAR, conflict still 1 after return to IDLE.
- Press during WALK: button at WALK cycle 2 -> ped_waiting=1 through FLASH/CLEAR. No new walk until street goes SG then SR0; then walk=1 again.
- Street stuck at RESET (5'h01) or illegal 5'h03 with request pending -> stays REQ, walk never asserts, conflict=0.
- PED_BTN_SYNC_EN defined, button held high 10 cycles -> exactly one btn_evt, ped_waiting rises 3 cycles after button; after WALK entry ped_waiting stays 0 while still held.
